// File: rtl/alumux_arbiter.sv
// Round-robin arbiter for two requesters sharing a single 4-function ALU.
// Each operation takes three cycles: grant (IDLE), compute (EXEC), respond (RESP).
module alumux_arbiter #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req_op,
    input  logic [2*N-1:0]   req_a,
    input  logic [2*N-1:0]   req_b,
    input  logic [2*N-1:0]   req_c,
    input  logic [2*N-1:0]   req_d,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2*N-1:0]   rsp_data,
    output logic             rsp_id,
    output logic             busy
);

    localparam int W = 2 * N;
    localparam logic [N:0] SHIFT_LIMIT = (N + 1)'(W);

    localparam logic [1:0] OP_ADD3 = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_SHR  = 2'b10;
    localparam logic [1:0] OP_SHL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [1:0]     rst_sync_r;
    logic           run_en_s;
    logic           last_grant_r;
    logic           grant_s;
    logic           grant_valid_s;
    logic           accept_s;
    logic [1:0]     req_ready_s;
    logic [1:0]     op_sel_s;
    logic [N-1:0]   a_sel_s;
    logic [N-1:0]   b_sel_s;
    logic [N-1:0]   c_sel_s;
    logic [N-1:0]   d_sel_s;
    logic [1:0]     op_r;
    logic [N-1:0]   a_r;
    logic [N-1:0]   b_r;
    logic [N-1:0]   c_r;
    logic [N-1:0]   d_r;
    logic           id_r;
    logic           rsp_valid_r;
    logic [W-1:0]   rsp_data_r;
    logic           rsp_id_r;
    logic           busy_r;

    // Operands are zero-extended to W bits; results wrap modulo 2^W.
    function automatic logic [W-1:0] alu_f(
        input logic [1:0]   op,
        input logic [N-1:0] a,
        input logic [N-1:0] b,
        input logic [N-1:0] c,
        input logic [N-1:0] d
    );
        logic [W-1:0] a_x;
        logic [W-1:0] b_x;
        logic [W-1:0] c_x;
        logic [W-1:0] res;
        logic         too_far;
        a_x     = {{N{1'b0}}, a};
        b_x     = {{N{1'b0}}, b};
        c_x     = {{N{1'b0}}, c};
        too_far = ({1'b0, d} >= SHIFT_LIMIT);
        case (op)
            OP_ADD3: res = a_x + b_x + c_x;
            OP_SUB:  res = c_x - b_x;
            OP_SHR:  res = too_far ? {W{1'b0}} : (a_x >> d);
            OP_SHL:  res = too_far ? {W{1'b0}} : (b_x << d);
            default: res = {W{1'b0}};
        endcase
        return res;
    endfunction

    // Reset release is resynchronised; grants are held off until it propagates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign run_en_s = rst_sync_r[1];

    // Round-robin selection: on contention, the requester not served last wins.
    always_comb begin
        grant_s       = 1'b0;
        grant_valid_s = 1'b0;
        case (req_valid)
            2'b01: begin
                grant_s       = 1'b0;
                grant_valid_s = 1'b1;
            end
            2'b10: begin
                grant_s       = 1'b1;
                grant_valid_s = 1'b1;
            end
            2'b11: begin
                grant_s       = ~last_grant_r;
                grant_valid_s = 1'b1;
            end
            default: begin
                grant_s       = 1'b0;
                grant_valid_s = 1'b0;
            end
        endcase
    end

    // Handshake qualification and operand selection for the granted requester.
    always_comb begin
        accept_s    = (state_r == IDLE) && run_en_s && grant_valid_s;
        req_ready_s = 2'b00;
        if (accept_s) begin
            req_ready_s = grant_s ? 2'b10 : 2'b01;
        end else begin
            req_ready_s = 2'b00;
        end
        op_sel_s = grant_s ? req_op[3:2]  : req_op[1:0];
        a_sel_s  = grant_s ? req_a[W-1:N] : req_a[N-1:0];
        b_sel_s  = grant_s ? req_b[W-1:N] : req_b[N-1:0];
        c_sel_s  = grant_s ? req_c[W-1:N] : req_c[N-1:0];
        d_sel_s  = grant_s ? req_d[W-1:N] : req_d[N-1:0];
    end

    // Next-state logic for the grant / execute / respond sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = EXEC;
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                state_s = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register plus registered status outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            rsp_valid_r <= (state_s == RESP);
            busy_r      <= (state_s != IDLE);
        end
    end

    // Operand capture at the request handshake; last_grant starts at 1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r         <= 2'b00;
            a_r          <= {N{1'b0}};
            b_r          <= {N{1'b0}};
            c_r          <= {N{1'b0}};
            d_r          <= {N{1'b0}};
            id_r         <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            op_r         <= op_sel_s;
            a_r          <= a_sel_s;
            b_r          <= b_sel_s;
            c_r          <= c_sel_s;
            d_r          <= d_sel_s;
            id_r         <= grant_s;
            last_grant_r <= grant_s;
        end
    end

    // Result register loads only in EXEC and holds through RESP back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_r <= {W{1'b0}};
            rsp_id_r   <= 1'b0;
        end else if (state_r == EXEC) begin
            rsp_data_r <= alu_f(op_r, a_r, b_r, c_r, d_r);
            rsp_id_r   <= id_r;
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_id    = rsp_id_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_alumux_arbiter.sv
// Directed self-checking bench for alumux_arbiter (N=4): inputs driven and
// outputs sampled just after the falling clock edge.
module tb_alumux_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [7:0] req_c;
    logic [7:0] req_d;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_id;
    logic       busy;

    int checks;
    int failures;

    alumux_arbiter #(.N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .req_d     (req_d),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b0;
        req_op = 4'h0; req_a = 8'h00; req_b = 8'h00; req_c = 8'h00; req_d = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_data !== 8'h00) begin failures++; $display("FAIL reset_rsp_data got %h exp 00", rsp_data); end
        checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL reset_rsp_id got %b exp 0", rsp_id); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
        @(negedge clk);
        rst_n = 1'b1; req_valid = 2'b00;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_r0;
        rsp_ready = 1'b1; req_valid = 2'b01; req_op = 4'b0000;
        req_a = 8'h03; req_b = 8'h04; req_c = 8'h05; req_d = 8'h00;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_ready got %b exp 01", req_ready); end
        @(negedge clk); req_valid = 2'b00; #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_exec got %b exp 1", busy); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_valid_exec got %b exp 0", rsp_valid); end
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL single_ready_exec got %b exp 00", req_ready); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_valid_resp got %b exp 1", rsp_valid); end
        checks++; if (rsp_data !== 8'h0C) begin failures++; $display("FAIL single_data got %h exp 0c", rsp_data); end
        checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL single_id got %b exp 0", rsp_id); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_resp got %b exp 1", busy); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_valid_done got %b exp 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_done got %b exp 0", busy); end
        @(negedge clk);
    endtask

    task automatic test_ops_r1;
        logic [1:0] v_op [4];
        logic [3:0] v_a [4];
        logic [3:0] v_b [4];
        logic [3:0] v_c [4];
        logic [3:0] v_d [4];
        logic [7:0] v_exp [4];
        v_op  = '{2'b01, 2'b10, 2'b11, 2'b11};
        v_a   = '{4'h0, 4'hC, 4'h0, 4'h0};
        v_b   = '{4'h2, 4'h0, 4'hF, 4'h1};
        v_c   = '{4'h1, 4'h0, 4'h0, 4'h0};
        v_d   = '{4'h0, 4'h2, 4'h4, 4'h9};
        v_exp = '{8'hFF, 8'h03, 8'hF0, 8'h00};
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 2'b10; req_op = {v_op[i], 2'b00};
            req_a = {v_a[i], 4'h0}; req_b = {v_b[i], 4'h0};
            req_c = {v_c[i], 4'h0}; req_d = {v_d[i], 4'h0};
            #1;
            checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL ops%0d_ready got %b exp 10", i, req_ready); end
            @(negedge clk); req_valid = 2'b00;
            @(negedge clk); #1;
            checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL ops%0d_valid got %b exp 1", i, rsp_valid); end
            checks++; if (rsp_data !== v_exp[i]) begin failures++; $display("FAIL ops%0d_data got %h exp %h", i, rsp_data, v_exp[i]); end
            checks++; if (rsp_id !== 1'b1) begin failures++; $display("FAIL ops%0d_id got %b exp 1", i, rsp_id); end
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin;
        int         g_id[$];
        int         g_cyc[$];
        int         r_id[$];
        logic [7:0] r_data[$];
        int         multi;
        logic [7:0] exp_data;
        multi = 0;
        rsp_ready = 1'b1; req_valid = 2'b11; req_op = {2'b01, 2'b00};
        req_a = 8'h01; req_b = 8'h11; req_c = 8'h51; req_d = 8'h00;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            if (req_ready == 2'b11) multi++;
            if (req_ready != 2'b00) begin g_id.push_back(int'(req_ready[1])); g_cyc.push_back(cyc); end
            if (rsp_valid) begin r_id.push_back(int'(rsp_id)); r_data.push_back(rsp_data); end
            @(negedge clk);
        end
        req_valid = 2'b00;
        checks++; if (multi !== 0) begin failures++; $display("FAIL rr_onehot got %0d exp 0", multi); end
        checks++; if (g_id.size() !== 4) begin failures++; $display("FAIL rr_grant_count got %0d exp 4", g_id.size()); end
        checks++; if (r_id.size() !== 4) begin failures++; $display("FAIL rr_rsp_count got %0d exp 4", r_id.size()); end
        for (int i = 0; i < g_id.size() && i < 4; i++) begin
            checks++; if (g_id[i] !== i % 2) begin failures++; $display("FAIL rr_grant%0d got %0d exp %0d", i, g_id[i], i % 2); end
            checks++; if (g_cyc[i] !== 3 * i) begin failures++; $display("FAIL rr_cycle%0d got %0d exp %0d", i, g_cyc[i], 3 * i); end
        end
        for (int i = 0; i < r_id.size() && i < 4; i++) begin
            exp_data = (i % 2 == 1) ? 8'h04 : 8'h03;
            checks++; if (r_id[i] !== i % 2) begin failures++; $display("FAIL rr_rsp_id%0d got %0d exp %0d", i, r_id[i], i % 2); end
            checks++; if (r_data[i] !== exp_data) begin failures++; $display("FAIL rr_rsp_data%0d got %h exp %h", i, r_data[i], exp_data); end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        rsp_ready = 1'b0; req_valid = 2'b01; req_op = {2'b00, 2'b11};
        req_a = 8'h00; req_b = 8'h03; req_c = 8'h00; req_d = 8'h01;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_ready_r0 got %b exp 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b10; req_op = {2'b01, 2'b11}; req_b = 8'h13; req_c = 8'h30;
        #1;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_ready_exec got %b exp 00", req_ready); end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_hold%0d_valid got %b exp 1", i, rsp_valid); end
            checks++; if (rsp_data !== 8'h06) begin failures++; $display("FAIL bp_hold%0d_data got %h exp 06", i, rsp_data); end
            checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL bp_hold%0d_id got %b exp 0", i, rsp_id); end
            checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_hold%0d_ready got %b exp 00", i, req_ready); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_release_ready got %b exp 00", req_ready); end
        @(negedge clk); #1;
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_next_grant got %b exp 10", req_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_idle_busy got %b exp 0", busy); end
        @(negedge clk); req_valid = 2'b00;
        @(negedge clk); #1;
        checks++; if (rsp_data !== 8'h02) begin failures++; $display("FAIL bp_r1_data got %h exp 02", rsp_data); end
        checks++; if (rsp_id !== 1'b1) begin failures++; $display("FAIL bp_r1_id got %b exp 1", rsp_id); end
        @(negedge clk);
    endtask

    task automatic test_operand_change;
        rsp_ready = 1'b1; req_valid = 2'b01; req_op = {2'b00, 2'b10};
        req_a = 8'h08; req_b = 8'h00; req_c = 8'h00; req_d = 8'h03;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL oc_ready_r0 got %b exp 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b10; req_op = {2'b00, 2'b10}; req_a = 8'h18; req_b = 8'h10; req_c = 8'h10;
        #1;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL oc_ready_exec got %b exp 00", req_ready); end
        @(negedge clk);
        req_op = {2'b01, 2'b10}; req_a = 8'h28; req_b = 8'h20; req_c = 8'h20;
        #1;
        checks++; if (rsp_data !== 8'h01) begin failures++; $display("FAIL oc_r0_data got %h exp 01", rsp_data); end
        checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL oc_r0_id got %b exp 0", rsp_id); end
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL oc_ready_resp got %b exp 00", req_ready); end
        @(negedge clk);
        req_op = {2'b00, 2'b10}; req_a = 8'h78; req_b = 8'h80; req_c = 8'h90;
        #1;
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL oc_ready_r1 got %b exp 10", req_ready); end
        @(negedge clk);
        req_valid = 2'b00; req_op = {2'b01, 2'b10}; req_a = 8'hF8; req_b = 8'hF0; req_c = 8'hF0;
        @(negedge clk); #1;
        checks++; if (rsp_data !== 8'h18) begin failures++; $display("FAIL oc_r1_data got %h exp 18", rsp_data); end
        checks++; if (rsp_id !== 1'b1) begin failures++; $display("FAIL oc_r1_id got %b exp 1", rsp_id); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_exec;
        rsp_ready = 1'b1; req_valid = 2'b01; req_op = 4'b0000;
        req_a = 8'h02; req_b = 8'h02; req_c = 8'h02; req_d = 8'h00;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_mid_ready got %b exp 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_pre got %b exp 1", busy); end
        #1; rst_n = 1'b0; #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got %b exp 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rst_mid_ready_low got %b exp 00", req_ready); end
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_post%0d_valid got %b exp 0", i, rsp_valid); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_post%0d_busy got %b exp 0", i, busy); end
        end
        req_valid = 2'b11; req_op = {2'b01, 2'b00};
        req_a = 8'h01; req_b = 8'h11; req_c = 8'h51; req_d = 8'h00;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_first_grant got %b exp 01", req_ready); end
        @(negedge clk); req_valid = 2'b00;
        @(negedge clk); #1;
        checks++; if (rsp_data !== 8'h03) begin failures++; $display("FAIL rst_after_data got %h exp 03", rsp_data); end
        checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL rst_after_id got %b exp 0", rsp_id); end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single_r0();
        test_ops_r1();
        test_round_robin();
        test_backpressure();
        test_operand_change();
        test_reset_mid_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "timeout");
    end

endmodule
